disp_sched: RTL and testbench

- Display-path controller between the calculator core and the digit pipeline (int_seg BCD converter -> serial digit shifter).
- Accepts new values over a valid/ready handshake and latches them.
- Sequences convert -> wait conv_done -> load shifter -> wait tran_done, then re-sends the held value at a fixed refresh period.
- Replaces the free-running load-pulse counter in the top level; adds overflow flagging and a stall timeout.

---
 rtl/disp_sched_pkg.sv | 23 ++
 rtl/disp_edge_det.sv | 21 ++
 rtl/disp_sched.sv | 137 +++++++++++++
 tb/tb_disp_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the display-path scheduler.
package disp_sched_pkg;

    localparam int unsigned DIGIT_NUM_W   = 14;
    localparam int unsigned DEF_MAX_VALUE = 9999;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONV      = 3'd1,
        ST_WAIT_CONV = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_TX   = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    // Shared refresh/timeout counter width: clog2 of the larger period, at least 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/disp_edge_det.sv
// Registers a level and emits a registered one-cycle pulse on its rising edge.
module disp_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev;
        end
    end

endmodule

// File: rtl/disp_sched.sv
// Display-path scheduler: latches calculator updates, sequences convert/load,
// refreshes the held value periodically and aborts stalled handshakes.
module disp_sched
    import disp_sched_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned MAX_VALUE      = DEF_MAX_VALUE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIGIT_NUM_W-1:0] upd_num,
    input  logic                   upd_err,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    output logic [DIGIT_NUM_W-1:0] conv_num,
    output logic                   conv_error,
    output logic                   conv_start,
    input  logic                   conv_done,
    output logic                   tx_load,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int unsigned CNT_W = cnt_width(REFRESH_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [DIGIT_NUM_W-1:0] MAX_NUM = DIGIT_NUM_W'(MAX_VALUE);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             conv_evt;
    logic             tx_evt;
    logic             accept;

    disp_edge_det u_conv_edge (
        .clk   (clk),
        .rst   (rst),
        .level (conv_done),
        .pulse (conv_evt)
    );

    disp_edge_det u_tx_edge (
        .clk   (clk),
        .rst   (rst),
        .level (tx_done),
        .pulse (tx_evt)
    );

    // upd_ready is only ever high in IDLE/HOLD, so this is the accept condition.
    assign accept = upd_valid & upd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            conv_num    <= '0;
            conv_error  <= 1'b0;
            conv_start  <= 1'b0;
            tx_load     <= 1'b0;
            upd_ready   <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            conv_start <= 1'b0;
            tx_load    <= 1'b0;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            unique case (state)
                ST_IDLE, ST_HOLD: begin
                    // A fresh update takes priority over a refresh expiring this cycle.
                    if (accept) begin
                        state       <= ST_CONV;
                        conv_num    <= upd_num;
                        conv_error  <= upd_err | (upd_num > MAX_NUM);
                        timeout_err <= 1'b0;
                        conv_start  <= 1'b1;
                        upd_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end else if (state == ST_HOLD && cnt == REFRESH_LAST) begin
                        state      <= ST_CONV;
                        conv_start <= 1'b1;
                        upd_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                ST_CONV: begin
                    state <= ST_WAIT_CONV;
                    cnt   <= '0;
                end

                ST_WAIT_CONV: begin
                    if (conv_evt) begin
                        state   <= ST_LOAD;
                        tx_load <= 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                        upd_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    state <= ST_WAIT_TX;
                    cnt   <= '0;
                end

                ST_WAIT_TX: begin
                    if (tx_evt) begin
                        state     <= ST_HOLD;
                        cnt       <= '0;
                        upd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                        upd_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    upd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// Randomised scoreboard bench for disp_sched: expected conv_start/tx_load pulses
// are queued from the stimulus timeline and checked by an independent monitor.
module tb_disp_sched;

    localparam int REF     = 16;
    localparam int TMO     = 32;
    localparam int LIMIT   = 9999;
    localparam int K_START = 0;
    localparam int K_LOAD  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] upd_num;
    logic        upd_err;
    logic        upd_valid;
    logic        upd_ready;
    logic [13:0] conv_num;
    logic        conv_error;
    logic        conv_start;
    logic        conv_done;
    logic        tx_load;
    logic        tx_done;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    disp_sched #(
        .REFRESH_CYCLES (REF),
        .TIMEOUT_CYCLES (TMO),
        .MAX_VALUE      (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_num     (upd_num),
        .upd_err     (upd_err),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .conv_num    (conv_num),
        .conv_error  (conv_error),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .tx_load     (tx_load),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int kind;
        int at;
        int num;
        int err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   held_num = 0;
    int   held_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_err(input int num, input int err);
        return (err != 0 || num > LIMIT) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int kind, input int at, input int num, input int err);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.num  = num;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Monitor: match each observed pulse against the head of the expectation queue.
    task automatic take(input int kind);
        int nk, na;
        n_tests++;
        if (sb.size() > 0 && sb[0].kind == kind && sb[0].at == cyc) begin
            if (kind == K_START && (int'(conv_num) != sb[0].num || int'(conv_error) != sb[0].err)) begin
                n_fail++;
                $display("FAIL start_payload at cycle %0d: got num=%0d err=%0d, expected num=%0d err=%0d",
                         cyc, conv_num, conv_error, sb[0].num, sb[0].err);
            end
            sb.delete(0);
        end else begin
            nk = (sb.size() > 0) ? sb[0].kind : -1;
            na = (sb.size() > 0) ? sb[0].at : -1;
            n_fail++;
            $display("FAIL unexpected_pulse kind=%0d at cycle %0d: got pulse, expected next kind=%0d at cycle %0d",
                     kind, cyc, nk, na);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_pulse kind=%0d: got none by cycle %0d, expected at cycle %0d",
                         sb[0].kind, cyc, sb[0].at);
                sb.delete(0);
            end
            if (conv_start) take(K_START);
            if (tx_load)    take(K_LOAD);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},   int'(upd_ready),   1);
        check({tag, "_num"},     int'(conv_num),    0);
        check({tag, "_err"},     int'(conv_error),  0);
        check({tag, "_start"},   int'(conv_start),  0);
        check({tag, "_load"},    int'(tx_load),     0);
        check({tag, "_busy"},    int'(busy),        0);
        check({tag, "_timeout"}, int'(timeout_err), 0);
    endtask

    task automatic rand_val(output int num, output int err);
        case ($urandom_range(0, 5))
            0:       num = 9999;
            1:       num = 10000;
            2:       num = 16383;
            3:       num = 0;
            default: num = int'($urandom_range(0, 16383));
        endcase
        err = ($urandom_range(0, 7) == 0) ? 1 : 0;
    endtask

    // Offer an update in an accepting cycle; conv_start follows one cycle later.
    task automatic send(input int num, input int err);
        check("ready_on_offer", int'(upd_ready), 1);
        upd_valid = 1'b1;
        upd_num   = 14'(num);
        upd_err   = (err != 0);
        push(K_START, cyc + 1, num, model_err(num, err));
        held_num = num;
        held_err = model_err(num, err);
        tick();
        upd_valid = 1'b0;
        check("busy_in_conv", int'(busy), 1);
        check("timeout_cleared", int'(timeout_err), 0);
    endtask

    // Called in the conv_start cycle; answers both handshakes and returns the first HOLD cycle.
    // With bp set, a new update is offered while busy and must be accepted exactly at HOLD entry.
    task automatic frame(input int cd, input int td, input bit bp, input int bnum, input int berr,
                         output int h);
        int s, n, m, hold_len;
        s = cyc;
        if (cd >= 3 && $urandom_range(0, 1) == 1) begin
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        goto(s + cd);
        conv_done = 1'b1;
        n = cyc;
        push(K_LOAD, n + 2, 0, 0);
        hold_len = int'($urandom_range(1, 3));
        repeat (hold_len) tick();
        conv_done = 1'b0;
        m = n + 2 + td;
        h = m + 2;
        if (bp) begin
            upd_valid = 1'b1;
            upd_num   = 14'(bnum);
            upd_err   = (berr != 0);
        end
        while (cyc < h) begin
            tx_done = (cyc == m);
            if (bp) check("bp_ready_low", int'(upd_ready), 0);
            tick();
        end
        tx_done = 1'b0;
        check("hold_not_busy", int'(busy), 0);
        check("hold_ready", int'(upd_ready), 1);
        if (bp) begin
            push(K_START, h + 1, bnum, model_err(bnum, berr));
            held_num = bnum;
            held_err = model_err(bnum, berr);
            tick();
            upd_valid = 1'b0;
        end
    endtask

    task automatic timeout_conv();
        int s;
        s = cyc;
        goto(s + TMO);
        check("tmo_conv_busy_last", int'(busy), 1);
        check("tmo_conv_flag_early", int'(timeout_err), 0);
        tick();
        check("tmo_conv_flag", int'(timeout_err), 1);
        check("tmo_conv_ready", int'(upd_ready), 1);
        check("tmo_conv_idle", int'(busy), 0);
    endtask

    task automatic timeout_tx();
        int s, n;
        s = cyc;
        goto(s + int'($urandom_range(1, 31)));
        conv_done = 1'b1;
        n = cyc;
        push(K_LOAD, n + 2, 0, 0);
        tick();
        conv_done = 1'b0;
        goto(n + 2 + TMO);
        check("tmo_tx_busy_last", int'(busy), 1);
        tick();
        check("tmo_tx_flag", int'(timeout_err), 1);
        check("tmo_tx_ready", int'(upd_ready), 1);
        check("tmo_tx_idle", int'(busy), 0);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  h;
        bit  pending;
        bit  idle;
        int  s;
        int  n;

        rst       = 1'b1;
        upd_valid = 1'b0;
        upd_num   = '0;
        upd_err   = 1'b0;
        conv_done = 1'b0;
        tx_done   = 1'b0;
        repeat (3) tick();
        check_reset("rst_init");
        rst = 1'b0;
        goto(cyc + 20);

        // Basic update followed by three untouched refreshes.
        send(6942, 0);
        frame(5, 4, 1'b0, 0, 0, h);
        for (int i = 0; i < 3; i++) begin
            push(K_START, h + REF, held_num, held_err);
            goto(h + REF - 1);
            check("ready_last_hold", int'(upd_ready), 1);
            goto(h + REF);
            frame(int'($urandom_range(1, 31)), int'($urandom_range(1, 31)), 1'b0, 0, 0, h);
        end

        // Overflow forcing the error, the largest legal value, then backpressure.
        goto(h + 4);
        send(12000, 0);
        frame(3, 2, 1'b0, 0, 0, h);
        send(9999, 0);
        frame(6, 3, 1'b1, 123, 0, h);
        frame(4, 4, 1'b0, 0, 0, h);
        check("bp_num_held", int'(conv_num), 123);

        // Converter stall, quiet IDLE afterwards, then recovery.
        goto(h + 2);
        send(500, 0);
        timeout_conv();
        goto(cyc + 40);
        check("timeout_sticky", int'(timeout_err), 1);
        send(77, 0);
        frame(31, 31, 1'b0, 0, 0, h);

        // Shifter stall.
        goto(h + 1);
        send(8888, 1);
        timeout_tx();
        goto(cyc + 3);
        send(10000, 0);
        frame(2, 5, 1'b0, 0, 0, h);

        pending = 1'b0;
        idle    = 1'b0;
        for (int r = 0; r < 50; r++) begin
            int kind, num, err, cd, td, bnum, berr;
            kind = int'($urandom_range(0, 9));
            rand_val(num, err);
            rand_val(bnum, berr);
            cd = (kind == 3) ? 31 : int'($urandom_range(1, 31));
            td = (kind == 4) ? 31 : int'($urandom_range(1, 31));
            if (pending) begin
                pending = 1'b0;
            end else if (idle) begin
                goto(cyc + int'($urandom_range(0, 5)));
                check("timeout_sticky_rnd", int'(timeout_err), 1);
                send(num, err);
                idle = 1'b0;
            end else if (kind == 0) begin
                push(K_START, h + REF, held_num, held_err);
                goto(h + REF);
            end else begin
                goto(h + ((kind == 1) ? REF - 1 : int'($urandom_range(0, REF - 1))));
                send(num, err);
            end
            if (kind == 8) begin
                timeout_conv();
                idle = 1'b1;
            end else if (kind == 9) begin
                timeout_tx();
                idle = 1'b1;
            end else begin
                frame(cd, td, kind == 2, bnum, berr, h);
                pending = (kind == 2);
            end
        end
        if (pending) frame(3, 3, 1'b0, 0, 0, h);

        // Asynchronous reset in WAIT_TX; a late tx_done must have no effect.
        send(4321, 0);
        s = cyc;
        goto(s + 3);
        conv_done = 1'b1;
        n = cyc;
        push(K_LOAD, n + 2, 0, 0);
        tick();
        conv_done = 1'b0;
        goto(n + 5);
        check("pre_rst_busy", int'(busy), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        tick();
        tick();
        rst     = 1'b0;
        tx_done = 1'b1;
        repeat (3) tick();
        tx_done = 1'b0;
        goto(cyc + 40);
        check_reset("post_rst");
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
